// File: rtl/mtr_spd_ramp.sv
// mtr_spd_ramp: slew-rate limiter for signed left/right motor speed commands.
module mtr_spd_ramp #(
  parameter int TICK_DIV = 512,
  parameter int STEP     = 8,
  parameter int SPD_LIM  = 1000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic signed [10:0] lft_cmd,
  input  logic signed [10:0] rght_cmd,
  input  logic               cmd_vld,
  input  logic               estop,
  output logic signed [10:0] lft_spd,
  output logic signed [10:0] rght_spd,
  output logic               at_tgt
);
  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic signed [11:0] STEP12 = 12'(STEP);
  localparam logic signed [10:0] LIM11 = 11'(SPD_LIM);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RAMP = 2'd1;
  localparam logic [1:0] STOP = 2'd2;
  logic [CW-1:0]     r_cnt;
  logic [1:0]        r_state;
  logic signed [10:0] r_lft_tgt, r_rght_tgt;
  logic signed [10:0] w_lft_nxt, w_rght_nxt, w_lft_clp, w_rght_clp;
  logic              w_tick;
  function automatic logic signed [10:0] f_clamp(input logic signed [10:0] c);
    return (c > LIM11) ? LIM11 : ((c < -LIM11) ? -LIM11 : c);
  endfunction
  // A step that would flip the sign of a moving output lands on zero instead.
  function automatic logic signed [10:0] f_step(input logic signed [10:0] spd, input logic signed [10:0] tgt);
    logic signed [11:0] diff, nxt;
    diff = $signed({tgt[10], tgt}) - $signed({spd[10], spd});
    nxt  = (diff <= STEP12 && diff >= -STEP12) ? $signed({tgt[10], tgt}) :
           (!diff[11] ? $signed({spd[10], spd}) + STEP12 : $signed({spd[10], spd}) - STEP12);
    return (spd != '0 && nxt != '0 && nxt[11] != spd[10]) ? '0 : nxt[10:0];
  endfunction
  assign w_tick     = r_cnt == CW'(TICK_DIV - 1);
  assign w_lft_clp  = f_clamp(lft_cmd);
  assign w_rght_clp = f_clamp(rght_cmd);
  assign w_lft_nxt  = f_step(lft_spd, r_lft_tgt);
  assign w_rght_nxt = f_step(rght_spd, r_rght_tgt);
  assign at_tgt     = (lft_spd == r_lft_tgt) && (rght_spd == r_rght_tgt) && (r_state != STOP);
  always_ff @(posedge clk) begin
    if (!rst_n || estop) begin
      r_cnt      <= '0;
      r_state    <= !rst_n ? IDLE : STOP;
      lft_spd    <= '0;
      rght_spd   <= '0;
      r_lft_tgt  <= '0;
      r_rght_tgt <= '0;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + CW'(1);
      if (r_state == STOP) begin
        r_state <= IDLE;
      end else if (cmd_vld) begin
        r_lft_tgt  <= w_lft_clp;
        r_rght_tgt <= w_rght_clp;
        r_state    <= (w_lft_clp != lft_spd || w_rght_clp != rght_spd) ? RAMP : IDLE;
      end else if (r_state == RAMP && w_tick) begin
        lft_spd  <= w_lft_nxt;
        rght_spd <= w_rght_nxt;
        r_state  <= (w_lft_nxt == r_lft_tgt && w_rght_nxt == r_rght_tgt) ? IDLE : RAMP;
      end
    end
  end
endmodule
